// File: rtl/usb_rx_phy.sv
// USB full-speed receive PHY: synchronizes D+/D-, recovers bits, NRZI-decodes, unstuffs, assembles bytes.
// Latency: ~4 clock48 cycles from a line edge to its bit sample; rx_valid one cycle after the 8th bit sample.
// Backpressure: none; rx_byte/rx_valid must be consumed in the pulse cycle.
//
// Ports: clock48/reset (async, active-high); data/data_n raw D+/D- lines;
//        rx_byte/rx_valid received byte + strobe; rx_active packet-in-progress level;
//        rx_eop/rx_error end-of-packet and error pulses; bus_reset SE0-held level.
// Optional feature: define USB_RX_STUFF_CHECK_EN to flag a stuff bit that decodes as 1.
module usb_rx_phy #(
    parameter int BUS_RESET_CYCLES = 120
) (
    input  logic       clock48,
    input  logic       reset,
    input  logic       data,
    input  logic       data_n,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_active,
    output logic       rx_eop,
    output logic       rx_error,
    output logic       bus_reset
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_WAIT_J = 2'd2;

    // Line states as {D+, D-}.
    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_SE1 = 2'b11;

    localparam int SE0_W = $clog2(BUS_RESET_CYCLES + 1);
    localparam logic [SE0_W-1:0] SE0_MAX  = SE0_W'(BUS_RESET_CYCLES);
    localparam logic [SE0_W-1:0] SE0_LAST = SE0_W'(BUS_RESET_CYCLES - 1);

    logic             d_meta, d_sync, dn_meta, dn_sync;
    logic [1:0]       line_prev;
    logic [1:0]       phase;
    logic             level_prev;   // 1 = last J/K sample was J
    logic [1:0]       state;
    logic [3:0]       hist;
    logic [2:0]       ones_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shifter;
    logic [SE0_W-1:0] se0_cnt;

    logic [1:0] line;
    logic       sample_en;
    logic       line_jk;
    logic       nrzi_bit;
    logic [7:0] shifter_next;

    assign line         = {d_sync, dn_sync};
    assign sample_en    = (phase == 2'd1);
    assign line_jk      = (line == LS_J) || (line == LS_K);
    assign nrzi_bit     = ~((line == LS_J) ^ level_prev);
    assign shifter_next = {nrzi_bit, shifter[7:1]};

    // Two-flop synchronizers on the raw lines.
    always_ff @(posedge clock48 or posedge reset) begin
        if (reset) begin
            d_meta  <= 1'b0;
            d_sync  <= 1'b0;
            dn_meta <= 1'b0;
            dn_sync <= 1'b0;
        end else begin
            d_meta  <= data;
            d_sync  <= d_meta;
            dn_meta <= data_n;
            dn_sync <= dn_meta;
        end
    end

    // Bit-phase recovery: realign on every line transition, sample at phase 1.
    always_ff @(posedge clock48 or posedge reset) begin
        if (reset) begin
            line_prev <= 2'b00;
            phase     <= 2'd0;
        end else begin
            line_prev <= line;
            if (line != line_prev) phase <= 2'd0;
            else                   phase <= phase + 2'd1;
        end
    end

    // Bus reset detection: saturating count of consecutive synchronized SE0 cycles.
    always_ff @(posedge clock48 or posedge reset) begin
        if (reset) begin
            se0_cnt   <= '0;
            bus_reset <= 1'b0;
        end else if (line == LS_SE0) begin
            if (se0_cnt != SE0_MAX) se0_cnt <= se0_cnt + 1'b1;
            if (se0_cnt >= SE0_LAST) bus_reset <= 1'b1;
        end else begin
            se0_cnt   <= '0;
            bus_reset <= 1'b0;
        end
    end

    // Receive FSM. The history is refilled with 1s whenever IDLE is (re)entered or
    // sees SE0/SE1, so a trailing J after an abort cannot fake the 0,0,0,1 sync tail.
    // Out of reset the synchronizers present SE0 at the first sample, which does the same.
    always_ff @(posedge clock48 or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            hist       <= 4'b0000;
            ones_cnt   <= 3'd0;
            bit_cnt    <= 3'd0;
            shifter    <= 8'h00;
            level_prev <= 1'b1;
            rx_byte    <= 8'h00;
            rx_valid   <= 1'b0;
            rx_active  <= 1'b0;
            rx_eop     <= 1'b0;
            rx_error   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_eop   <= 1'b0;
            rx_error <= 1'b0;

            if (sample_en && line_jk) level_prev <= (line == LS_J);

            if (bus_reset) begin
                state     <= ST_IDLE;
                hist      <= 4'b1111;
                rx_active <= 1'b0;
            end else if (sample_en) begin
                case (state)
                    ST_IDLE: begin
                        if (line_jk) begin
                            hist <= {hist[2:0], nrzi_bit};
                            if ({hist[2:0], nrzi_bit} == 4'b0001) begin
                                state     <= ST_ACTIVE;
                                rx_active <= 1'b1;
                                ones_cnt  <= 3'd0;
                                bit_cnt   <= 3'd0;
                                shifter   <= 8'h00;
                            end
                        end else begin
                            hist <= 4'b1111;
                        end
                    end

                    ST_ACTIVE: begin
                        if (line == LS_SE1) begin
                            state     <= ST_IDLE;
                            hist      <= 4'b1111;
                            rx_active <= 1'b0;
                            rx_error  <= 1'b1;
                        end else if (line == LS_SE0) begin
                            state <= ST_WAIT_J;
                        end else if (ones_cnt == 3'd6) begin
                            // Stuff bit: never enters the shifter.
                            ones_cnt <= 3'd0;
`ifdef USB_RX_STUFF_CHECK_EN
                            if (nrzi_bit) begin
                                state     <= ST_IDLE;
                                hist      <= 4'b1111;
                                rx_active <= 1'b0;
                                rx_error  <= 1'b1;
                            end
`else
`endif
                        end else begin
                            ones_cnt <= nrzi_bit ? ones_cnt + 3'd1 : 3'd0;
                            shifter  <= shifter_next;
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rx_byte  <= shifter_next;
                                rx_valid <= 1'b1;
                            end
                        end
                    end

                    ST_WAIT_J: begin
                        if (line == LS_J) begin
                            state     <= ST_IDLE;
                            hist      <= 4'b1111;
                            rx_active <= 1'b0;
                            rx_eop    <= 1'b1;
                            rx_error  <= (bit_cnt != 3'd0);
                        end else if (line != LS_SE0) begin
                            // K or SE1 where the EOP's closing J belongs.
                            state     <= ST_IDLE;
                            hist      <= 4'b1111;
                            rx_active <= 1'b0;
                            rx_error  <= 1'b1;
                        end
                    end

                    default: begin
                        state     <= ST_IDLE;
                        hist      <= 4'b1111;
                        rx_active <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/usb_rx_phy.md
USB_RX_PHY -- requirements
Module: usb_rx_phy

Interface
REQ-001 SHALL have parameter: BUS_RESET_CYCLES, 120, number of consecutive SE0 clock48 cycles that flag a bus reset (2.5 us at 48 MHz).
REQ-002 SHALL have ports:
- clock48  input  1  48 MHz system clock; the only clock.
- reset  input  1  asynchronous, active-high reset.
- data  input  1  raw D+ line, asynchronous to clock48.
- data_n  input  1  raw D- line, asynchronous to clock48.
- rx_byte  output  8  last assembled byte, LSB received first.
- rx_valid  output  1  one-cycle pulse; rx_byte is valid in that cycle.
- rx_active  output  1  high from sync detection through EOP or abort.
- rx_eop  output  1  one-cycle pulse on end of packet.
- rx_error  output  1  one-cycle pulse on stuff error, SE1, or partial byte at EOP.
- bus_reset  output  1  level; high while SE0 has persisted for at least BUS_RESET_CYCLES cycles.

Function
REQ-003 SHALL pass data and data_n each through a two-flop synchronizer before any use.
REQ-004 SHALL classify synchronized lines: J = (1,0), K = (0,1), SE0 = (0,0), SE1 = (1,1).
REQ-005 SHALL run a 2-bit phase counter that clears to 0 on any change of synchronized line state and otherwise increments, wrapping 3 to 0.
REQ-006 SHALL take one bit sample in each cycle where the phase counter equals 1.
REQ-007 SHALL NRZI-decode each J/K sample: the same level as the previous sample decodes as 1, and a change decodes as 0.
REQ-008 SHALL use the states IDLE, ACTIVE, and WAIT_J.
REQ-009 IDLE: SHALL shift decoded bits into a 4-bit history and go to ACTIVE, asserting rx_active, when the history (oldest to newest) is 0,0,0,1, which is the KJKK sync tail.
REQ-010 ACTIVE: SHALL count consecutive decoded 1s; after six 1s, the next sample is a stuff bit, which is dropped and the counter cleared.
REQ-011 ACTIVE: SHALL shift each non-stuff bit into an 8-bit shifter LSB-first; on the 8th bit it loads rx_byte and pulses rx_valid in the next cycle (1-cycle latency from the sample).
REQ-012 ACTIVE: an SE0 sample SHALL go to WAIT_J; a J sample in WAIT_J pulses rx_eop, deasserts rx_active the same cycle, and returns to IDLE.
REQ-013 EOP with a nonzero partial bit count SHALL pulse rx_error together with rx_eop and suppress rx_valid for the partial byte.
REQ-014 Any SE1 sample while ACTIVE or WAIT_J SHALL pulse rx_error, drop rx_active, and go to IDLE; no rx_eop is emitted.
REQ-015 A K sample in WAIT_J SHALL pulse rx_error and go to IDLE.
REQ-016 SHALL count consecutive SE0 cycles (unsampled) with a saturating counter; bus_reset rises when the count reaches BUS_RESET_CYCLES and falls in the first cycle a non-SE0 state is synchronized.
REQ-017 Bus reset SHALL force the FSM to IDLE and rx_active low, without an rx_eop pulse.
REQ-018 rx_valid, rx_eop, and rx_error SHALL never be high for more than one consecutive cycle.

Reset
REQ-019 reset SHALL asynchronously clear everything to its idle state: rx_byte = 0x00; rx_valid, rx_active, rx_eop, rx_error, and bus_reset = 0; FSM = IDLE; all counters, the history, the shifter, and the synchronizers = 0; the previous NRZI level = J.
REQ-020 reset asserted mid-packet SHALL abort the packet; after release, reception resumes only on a new sync.

Configuration
REQ-021 Macro USB_RX_STUFF_CHECK_EN defined: a stuff-bit sample that decodes as 1 SHALL pulse rx_error, drop rx_active, and go to IDLE.
REQ-022 Macro USB_RX_STUFF_CHECK_EN undefined: the stuff bit SHALL be dropped regardless of its value and no stuff error is reported.

Verification
REQ-023 SHALL cover these scenarios:
- Idle J for 10 us, then sync KJKJKJKK, byte 0x2D NRZI-encoded at 83.33 ns/bit, SE0 for 2 bits, then J -> one rx_valid with rx_byte = 0x2D, then rx_eop; rx_error never pulses.
- Byte 0xFF followed by byte 0x01, with the stuff bit inserted after the sixth 1 -> rx_byte 0xFF, then 0x01; no error.
- Stuff position driven as 1 (seven 1s) -> with USB_RX_STUFF_CHECK_EN: rx_error pulse and rx_active low; without it: no error.
- Sync, 5 data bits, then SE0/J -> rx_eop and rx_error in the same cycle; no rx_valid.
- SE0 for 30 ms, then J -> bus_reset high 120 cycles after SE0 is synchronized and low within 3 cycles of J; no rx_eop.
- reset pulsed after 4 data bits of a packet -> all outputs 0; the following full packet 0xA5 is received as 0xA5.
